// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM sequencing fetch, decode, execute, memory and writeback.
// Holds the instruction register; traps stickily on illegal opcode or memory timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [2:0]  imm_sel,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  err_code
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state_q, state_d;
    logic [31:0]          instr_q, instr_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           err_q, err_d;
    logic                 is_opimm, is_load, is_op, is_store, is_branch, is_lui, is_jal, is_legal;
    logic                 st_ex, st_mem, st_wb;

    assign is_opimm  = instr_q[6:0] == 7'b0010011;
    assign is_load   = instr_q[6:0] == 7'b0000011;
    assign is_op     = instr_q[6:0] == 7'b0110011;
    assign is_store  = instr_q[6:0] == 7'b0100011;
    assign is_branch = instr_q[6:0] == 7'b1100011;
    assign is_lui    = instr_q[6:0] == 7'b0110111;
    assign is_jal    = instr_q[6:0] == 7'b1101111;
    assign is_legal  = is_opimm | is_load | is_op | is_store | is_branch | is_lui | is_jal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            instr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A ready arriving on the limit cycle is checked first, so it wins over the timeout.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_TRAP;
                        err_d   = 2'b10;
                    end
                end
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXEC : S_TRAP;
                err_d   = is_legal ? err_q : 2'b01;
            end
            S_EXEC:   state_d = is_branch ? S_FETCH : (is_load | is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    cnt_d   = '0;
                    state_d = is_load ? S_WB : S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_TRAP;
                        err_d   = 2'b11;
                    end
                end
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
    end

    assign st_ex  = state_q == S_EXEC;
    assign st_mem = state_q == S_MEM;
    assign st_wb  = state_q == S_WB;

    // imem_req is gated by rst_n because reset parks the FSM in FETCH.
    always_comb begin
        imem_req    = rst_n & (state_q == S_FETCH);
        imm_sel     = (state_q == S_TRAP) ? 3'd0 :
                      (is_opimm | is_load) ? 3'd1 :
                      is_store ? 3'd2 : is_branch ? 3'd3 : is_lui ? 3'd4 : is_jal ? 3'd5 : 3'd0;
        alu_src_imm = st_ex & ~(is_op | is_branch);
        alu_op      = !st_ex ? 2'b00 : (is_op | is_opimm) ? 2'b01 :
                      is_branch ? 2'b10 : is_lui ? 2'b11 : 2'b00;
        pc_we       = (st_ex & is_branch) | (st_mem & is_store & dmem_ready) | st_wb;
        pc_sel      = (st_ex & is_branch & branch_taken) | (st_wb & is_jal);
        dmem_req    = st_mem;
        dmem_we     = st_mem & is_store;
        rf_we       = st_wb & (|instr_q[11:7]);
        wb_sel      = !st_wb ? 2'b00 : is_load ? 2'b01 : is_jal ? 2'b10 : is_lui ? 2'b11 : 2'b00;
        err_code    = err_q;
        instr       = instr_q;
    end
endmodule
